// File: rtl/inst_buffer_fs2.sv
// Instruction buffer between FetchStage2 and Decode.
// Compacts up to 4 valid packets per cycle into a circular FIFO and releases groups of 4.
module inst_buffer_fs2 #(
    parameter int PKT_W = 133,
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             fs2Ready_i,
    input  logic             inst0Valid_i,
    input  logic             inst1Valid_i,
    input  logic             inst2Valid_i,
    input  logic             inst3Valid_i,
    input  logic [PKT_W-1:0] inst0Packet_i,
    input  logic [PKT_W-1:0] inst1Packet_i,
    input  logic [PKT_W-1:0] inst2Packet_i,
    input  logic [PKT_W-1:0] inst3Packet_i,
    input  logic             stall_i,
    output logic             bufferFull_o,
    output logic             instBufferReady_o,
    output logic [PKT_W-1:0] inst0Packet_o,
    output logic [PKT_W-1:0] inst1Packet_o,
    output logic [PKT_W-1:0] inst2Packet_o,
    output logic [PKT_W-1:0] inst3Packet_o,
    output logic [PTR_W:0]   count_o
);

    localparam logic [PTR_W:0] FOUR    = (PTR_W+1)'(4);
    localparam logic [PTR_W:0] FULL_TH = (PTR_W+1)'(DEPTH - 4);

    logic [PKT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    logic [3:0]       valid;
    logic [PKT_W-1:0] pkt_in [4];
    logic [PTR_W-1:0] wr_idx [4];
    logic [PTR_W-1:0] rd_idx [4];
    logic [3:0]       wr_en;
    logic [PTR_W-1:0] off;
    logic [PTR_W:0]   n_wr;
    logic             wr;
    logic             rd;

    assign valid     = {inst3Valid_i, inst2Valid_i, inst1Valid_i, inst0Valid_i};
    assign pkt_in[0] = inst0Packet_i;
    assign pkt_in[1] = inst1Packet_i;
    assign pkt_in[2] = inst2Packet_i;
    assign pkt_in[3] = inst3Packet_i;

    // Full is judged on registered occupancy only; same-cycle reads are not credited.
    assign bufferFull_o      = count_q > FULL_TH;
    assign instBufferReady_o = (count_q >= FOUR) & ~flush_i & ~reset;
    assign wr                = fs2Ready_i & ~bufferFull_o & ~flush_i & ~reset;
    assign rd                = instBufferReady_o & ~stall_i;
    assign count_o           = count_q;

    // Each valid slot lands at tail plus the number of valid slots before it.
    always_comb begin
        off = '0;
        for (int i = 0; i < 4; i++) begin
            wr_idx[i] = tail_q + off;
            wr_en[i]  = wr & valid[i];
            off       = off + PTR_W'(valid[i]);
        end
        n_wr = {1'b0, off};
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rd_idx[i] = head_q + PTR_W'(i);
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (wr) tail_d = tail_q + off;
            if (rd) head_d = head_q + PTR_W'(4);
            count_d = count_q + (wr ? n_wr : '0) - (rd ? FOUR : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en[i]) mem_q[wr_idx[i]] <= pkt_in[i];
        end
    end

    assign inst0Packet_o = instBufferReady_o ? mem_q[rd_idx[0]] : '0;
    assign inst1Packet_o = instBufferReady_o ? mem_q[rd_idx[1]] : '0;
    assign inst2Packet_o = instBufferReady_o ? mem_q[rd_idx[2]] : '0;
    assign inst3Packet_o = instBufferReady_o ? mem_q[rd_idx[3]] : '0;

endmodule

// File: tb/tb_inst_buffer_fs2.sv
// Directed self-checking bench for inst_buffer_fs2.
// Status is checked as {ready, full, count}; outputs as the 4-packet head window.
module tb_inst_buffer_fs2;

    localparam int PKT_W = 133;
    localparam int DEPTH = 16;
    localparam int PTR_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush_i;
    logic             fs2Ready_i;
    logic             v0, v1, v2, v3;
    logic [PKT_W-1:0] p0, p1, p2, p3;
    logic             stall_i;
    logic             bufferFull_o;
    logic             instBufferReady_o;
    logic [PKT_W-1:0] o0, o1, o2, o3;
    logic [PTR_W:0]   count_o;

    logic [6:0]       status;
    logic [4*PKT_W-1:0] outs;

    int n_chk  = 0;
    int n_fail = 0;

    assign status = {instBufferReady_o, bufferFull_o, count_o};
    assign outs   = {o0, o1, o2, o3};

    inst_buffer_fs2 #(.PKT_W(PKT_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .flush_i           (flush_i),
        .fs2Ready_i        (fs2Ready_i),
        .inst0Valid_i      (v0),
        .inst1Valid_i      (v1),
        .inst2Valid_i      (v2),
        .inst3Valid_i      (v3),
        .inst0Packet_i     (p0),
        .inst1Packet_i     (p1),
        .inst2Packet_i     (p2),
        .inst3Packet_i     (p3),
        .stall_i           (stall_i),
        .bufferFull_o      (bufferFull_o),
        .instBufferReady_o (instBufferReady_o),
        .inst0Packet_o     (o0),
        .inst1Packet_o     (o1),
        .inst2Packet_o     (o2),
        .inst3Packet_o     (o3),
        .count_o           (count_o)
    );

    always #5 clk = ~clk;

    function automatic logic [PKT_W-1:0] pk(input logic [7:0] t);
        return {t, {(PKT_W-16){1'b0}}, t};
    endfunction

    function automatic logic [4*PKT_W-1:0] pk4(input logic [7:0] a, b, c, d);
        return {pk(a), pk(b), pk(c), pk(d)};
    endfunction

    function automatic logic [6:0] st(input logic r, input logic f, input int c);
        return {r, f, 5'(c)};
    endfunction

    // v[0] is slot 0.
    task automatic drive(input logic rdy, input logic [3:0] v,
                         input logic [7:0] a, b, c, d,
                         input logic stl, input logic fl);
        fs2Ready_i = rdy;
        {v3, v2, v1, v0} = v;
        p0 = pk(a);
        p1 = pk(b);
        p2 = pk(c);
        p3 = pk(d);
        stall_i = stl;
        flush_i = fl;
        #1;
    endtask

    task automatic idle(input logic stl);
        drive(1'b1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, stl, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(1'b0);
        step();
        step();
        reset = 1'b0;
        idle(1'b0);
        n_chk++;
        if (status !== st(0, 0, 0)) begin
            n_fail++;
            $display("FAIL reset_status: got %b want %b", status, st(0, 0, 0));
        end
        n_chk++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL reset_outs: got %h want 0", outs);
        end
    endtask

    task automatic test_stream();
        drive(1'b1, 4'b1111, 8'h01, 8'h02, 8'h03, 8'h04, 1'b0, 1'b0);
        n_chk++;
        if (status !== st(0, 0, 0)) begin
            n_fail++;
            $display("FAIL stream_first: got %b want %b", status, st(0, 0, 0));
        end
        step();
        for (int k = 0; k < 4; k++) begin
            if (k < 3)
                drive(1'b1, 4'b1111, 8'(4*k+5), 8'(4*k+6), 8'(4*k+7), 8'(4*k+8), 1'b0, 1'b0);
            else
                idle(1'b0);
            n_chk++;
            if (status !== st(1, 0, 4)) begin
                n_fail++;
                $display("FAIL stream_status%0d: got %b want %b", k, status, st(1, 0, 4));
            end
            n_chk++;
            if (outs !== pk4(8'(4*k+1), 8'(4*k+2), 8'(4*k+3), 8'(4*k+4))) begin
                n_fail++;
                $display("FAIL stream_outs%0d: got %h want %h", k, outs,
                         pk4(8'(4*k+1), 8'(4*k+2), 8'(4*k+3), 8'(4*k+4)));
            end
            step();
        end
        idle(1'b0);
        n_chk++;
        if (status !== st(0, 0, 0)) begin
            n_fail++;
            $display("FAIL stream_drained: got %b want %b", status, st(0, 0, 0));
        end
    endtask

    task automatic test_compact();
        drive(1'b0, 4'b1111, 8'h55, 8'h55, 8'h55, 8'h55, 1'b0, 1'b0);
        step();
        drive(1'b1, 4'b0000, 8'h55, 8'h55, 8'h55, 8'h55, 1'b0, 1'b0);
        n_chk++;
        if (status !== st(0, 0, 0)) begin
            n_fail++;
            $display("FAIL compact_nordy: got %b want %b", status, st(0, 0, 0));
        end
        step();
        drive(1'b1, 4'b0001, 8'hA1, 8'hEE, 8'hEE, 8'hEE, 1'b0, 1'b0);
        n_chk++;
        if (status !== st(0, 0, 0)) begin
            n_fail++;
            $display("FAIL compact_novalid: got %b want %b", status, st(0, 0, 0));
        end
        step();
        drive(1'b1, 4'b0011, 8'hB2, 8'hC3, 8'hEE, 8'hEE, 1'b0, 1'b0);
        step();
        drive(1'b1, 4'b0101, 8'hD4, 8'hEE, 8'hE5, 8'hEE, 1'b0, 1'b0);
        n_chk++;
        if (status !== st(0, 0, 3)) begin
            n_fail++;
            $display("FAIL compact_three: got %b want %b", status, st(0, 0, 3));
        end
        step();
        drive(1'b1, 4'b1000, 8'hEE, 8'hEE, 8'hEE, 8'hF6, 1'b0, 1'b0);
        n_chk++;
        if (status !== st(1, 0, 5)) begin
            n_fail++;
            $display("FAIL compact_five: got %b want %b", status, st(1, 0, 5));
        end
        n_chk++;
        if (outs !== pk4(8'hA1, 8'hB2, 8'hC3, 8'hD4)) begin
            n_fail++;
            $display("FAIL compact_outs1: got %h want %h", outs, pk4(8'hA1, 8'hB2, 8'hC3, 8'hD4));
        end
        step();
        drive(1'b1, 4'b0011, 8'h17, 8'h18, 8'hEE, 8'hEE, 1'b0, 1'b0);
        n_chk++;
        if (status !== st(0, 0, 2)) begin
            n_fail++;
            $display("FAIL compact_two: got %b want %b", status, st(0, 0, 2));
        end
        step();
        idle(1'b0);
        n_chk++;
        if (outs !== pk4(8'hE5, 8'hF6, 8'h17, 8'h18)) begin
            n_fail++;
            $display("FAIL compact_outs2: got %h want %h", outs, pk4(8'hE5, 8'hF6, 8'h17, 8'h18));
        end
        step();
    endtask

    task automatic test_stall();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 4'b1111, 8'(8'h20+4*k), 8'(8'h21+4*k), 8'(8'h22+4*k), 8'(8'h23+4*k), 1'b1, 1'b0);
            n_chk++;
            if (status !== st(k > 0, 0, 4*k)) begin
                n_fail++;
                $display("FAIL stall_fill%0d: got %b want %b", k, status, st(k > 0, 0, 4*k));
            end
            step();
        end
        drive(1'b1, 4'b1111, 8'h60, 8'h61, 8'h62, 8'h63, 1'b1, 1'b0);
        n_chk++;
        if (status !== st(1, 1, 16)) begin
            n_fail++;
            $display("FAIL stall_full16: got %b want %b", status, st(1, 1, 16));
        end
        step();
        idle(1'b0);
        n_chk++;
        if (status !== st(1, 1, 16)) begin
            n_fail++;
            $display("FAIL stall_blocked: got %b want %b", status, st(1, 1, 16));
        end
        n_chk++;
        if (outs !== pk4(8'h20, 8'h21, 8'h22, 8'h23)) begin
            n_fail++;
            $display("FAIL stall_outs0: got %h want %h", outs, pk4(8'h20, 8'h21, 8'h22, 8'h23));
        end
        step();
        drive(1'b1, 4'b0001, 8'h30, 8'hEE, 8'hEE, 8'hEE, 1'b1, 1'b0);
        n_chk++;
        if (status !== st(1, 0, 12)) begin
            n_fail++;
            $display("FAIL stall_twelve: got %b want %b", status, st(1, 0, 12));
        end
        step();
        drive(1'b1, 4'b1111, 8'h70, 8'h71, 8'h72, 8'h73, 1'b1, 1'b0);
        n_chk++;
        if (status !== st(1, 1, 13)) begin
            n_fail++;
            $display("FAIL stall_full13: got %b want %b", status, st(1, 1, 13));
        end
        step();
        for (int k = 0; k < 3; k++) begin
            idle(1'b0);
            n_chk++;
            if (status !== st(1, k == 0, 13 - 4*k)) begin
                n_fail++;
                $display("FAIL stall_drain%0d: got %b want %b", k, status, st(1, k == 0, 13 - 4*k));
            end
            n_chk++;
            if (outs !== pk4(8'(8'h24+4*k), 8'(8'h25+4*k), 8'(8'h26+4*k), 8'(8'h27+4*k))) begin
                n_fail++;
                $display("FAIL stall_drain_outs%0d: got %h want %h", k, outs,
                         pk4(8'(8'h24+4*k), 8'(8'h25+4*k), 8'(8'h26+4*k), 8'(8'h27+4*k)));
            end
            step();
        end
        drive(1'b1, 4'b0111, 8'h31, 8'h32, 8'h33, 8'hEE, 1'b0, 1'b0);
        n_chk++;
        if (status !== st(0, 0, 1)) begin
            n_fail++;
            $display("FAIL stall_one: got %b want %b", status, st(0, 0, 1));
        end
        step();
        idle(1'b0);
        n_chk++;
        if (outs !== pk4(8'h30, 8'h31, 8'h32, 8'h33)) begin
            n_fail++;
            $display("FAIL stall_tail_outs: got %h want %h", outs, pk4(8'h30, 8'h31, 8'h32, 8'h33));
        end
        step();
    endtask

    task automatic test_wrap();
        // Pointers start at 12 here, so the W bundle lands on 14, 15, 0, 1.
        drive(1'b1, 4'b0011, 8'h40, 8'h41, 8'hEE, 8'hEE, 1'b0, 1'b0);
        step();
        drive(1'b1, 4'b1111, 8'h50, 8'h51, 8'h52, 8'h53, 1'b0, 1'b0);
        n_chk++;
        if (status !== st(0, 0, 2)) begin
            n_fail++;
            $display("FAIL wrap_pre: got %b want %b", status, st(0, 0, 2));
        end
        step();
        drive(1'b1, 4'b0011, 8'h42, 8'h43, 8'hEE, 8'hEE, 1'b0, 1'b0);
        n_chk++;
        if (outs !== pk4(8'h40, 8'h41, 8'h50, 8'h51)) begin
            n_fail++;
            $display("FAIL wrap_outs0: got %h want %h", outs, pk4(8'h40, 8'h41, 8'h50, 8'h51));
        end
        step();
        idle(1'b0);
        n_chk++;
        if (status !== st(1, 0, 4)) begin
            n_fail++;
            $display("FAIL wrap_count: got %b want %b", status, st(1, 0, 4));
        end
        n_chk++;
        if (outs !== pk4(8'h52, 8'h53, 8'h42, 8'h43)) begin
            n_fail++;
            $display("FAIL wrap_outs1: got %h want %h", outs, pk4(8'h52, 8'h53, 8'h42, 8'h43));
        end
        step();
    endtask

    task automatic test_flush();
        drive(1'b1, 4'b1111, 8'h80, 8'h81, 8'h82, 8'h83, 1'b1, 1'b0);
        step();
        drive(1'b1, 4'b1111, 8'h84, 8'h85, 8'h86, 8'h87, 1'b1, 1'b0);
        step();
        drive(1'b1, 4'b0011, 8'h88, 8'h89, 8'hEE, 8'hEE, 1'b1, 1'b0);
        step();
        drive(1'b1, 4'b1111, 8'hE0, 8'hE1, 8'hE2, 8'hE3, 1'b0, 1'b1);
        n_chk++;
        if (status !== st(0, 0, 10)) begin
            n_fail++;
            $display("FAIL flush_cycle: got %b want %b", status, st(0, 0, 10));
        end
        n_chk++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL flush_cycle_outs: got %h want 0", outs);
        end
        step();
        drive(1'b1, 4'b1111, 8'h90, 8'h91, 8'h92, 8'h93, 1'b0, 1'b0);
        n_chk++;
        if (status !== st(0, 0, 0)) begin
            n_fail++;
            $display("FAIL flush_after: got %b want %b", status, st(0, 0, 0));
        end
        step();
        idle(1'b0);
        n_chk++;
        if (outs !== pk4(8'h90, 8'h91, 8'h92, 8'h93)) begin
            n_fail++;
            $display("FAIL flush_outs: got %h want %h", outs, pk4(8'h90, 8'h91, 8'h92, 8'h93));
        end
        step();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 4'b1111, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 1'b0, 1'b0);
        step();
        drive(1'b1, 4'b0111, 8'hB4, 8'hB5, 8'hB6, 8'hEE, 1'b0, 1'b0);
        step();
        drive(1'b1, 4'b1111, 8'hB7, 8'hB8, 8'hB9, 8'hBA, 1'b0, 1'b0);
        step();
        idle(1'b0);
        n_chk++;
        if (status !== st(1, 0, 7) || outs !== pk4(8'hB4, 8'hB5, 8'hB6, 8'hB7)) begin
            n_fail++;
            $display("FAIL rstmid_pre: got %b %h want %b %h", status, outs,
                     st(1, 0, 7), pk4(8'hB4, 8'hB5, 8'hB6, 8'hB7));
        end
        reset = 1'b1;
        drive(1'b1, 4'b1111, 8'hC0, 8'hC1, 8'hC2, 8'hC3, 1'b0, 1'b0);
        step();
        reset = 1'b0;
        drive(1'b1, 4'b1111, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 1'b0, 1'b0);
        n_chk++;
        if (status !== st(0, 0, 0)) begin
            n_fail++;
            $display("FAIL rstmid_status: got %b want %b", status, st(0, 0, 0));
        end
        n_chk++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outs: got %h want 0", outs);
        end
        step();
        idle(1'b0);
        n_chk++;
        if (outs !== pk4(8'hA0, 8'hA1, 8'hA2, 8'hA3)) begin
            n_fail++;
            $display("FAIL rstmid_first: got %h want %h", outs, pk4(8'hA0, 8'hA1, 8'hA2, 8'hA3));
        end
        step();
    endtask

    initial begin
        reset      = 1'b1;
        flush_i    = 1'b0;
        fs2Ready_i = 1'b0;
        {v3, v2, v1, v0} = 4'b0000;
        p0 = '0;
        p1 = '0;
        p2 = '0;
        p3 = '0;
        stall_i = 1'b0;
        test_reset();
        test_stream();
        test_compact();
        test_stall();
        test_wrap();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_buffer_fs2.md
Name: inst_buffer_fs2

Overview:
- Instruction buffer between FetchStage2 and Decode.
- Each cycle it accepts up to 4 instruction packets from FetchStage2, using the per-slot valid bits. It compacts the valid packets in program order and writes them into a circular FIFO.
- Toward Decode it releases exactly 4 packets per cycle, in order. A release happens only when at least 4 packets are buffered and Decode is not stalled.
- It back-pressures fetch through bufferFull_o and discards all contents on recovery or flush.

Parameters:
- PKT_W, 133, packet width: SIZE_INSTRUCTION + 2*SIZE_PC + SIZE_CTI_LOG + 1 (64+64+4+1).
- DEPTH, 16, number of buffer entries; must be a power of two and at least 8.
- PTR_W, 4, log2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush_i  in  1  pipeline flush / branch recovery (recoverFlag); discards all contents.
- fs2Ready_i  in  1  FetchStage2 bundle is ready this cycle.
- inst0Valid_i..inst3Valid_i  in  1 each  per-slot valid bits from FetchStage2 (its filterVector).
- inst0Packet_i..inst3Packet_i  in  PKT_W each  packet as {instruction, pc, targetAddr, ctiqTag, prediction}.
- stall_i  in  1  Decode/backend stall.
- bufferFull_o  out  1  stall fetch; the bundle this cycle is not accepted.
- instBufferReady_o  out  1  four packets are presented to Decode this cycle.
- inst0Packet_o..inst3Packet_o  out  PKT_W each  head entries head+0..head+3.
- count_o  out  PTR_W+1  current occupancy, for debug and performance counters.

Behaviour:
- Storage: DEPTH x PKT_W array, head and tail pointers of PTR_W bits that wrap modulo DEPTH, and count of PTR_W+1 bits.
- Reset (synchronous; the reset cycle has priority over everything):
  - head=0, tail=0, count=0.
  - bufferFull_o=0, instBufferReady_o=0, all outputs 0.
  - Array contents are don't-care.
- bufferFull_o: combinational from registered count; equals 1 when DEPTH - count < 4. Same-cycle reads are not credited, so the write side can never overflow.
- Write enable: wr = fs2Ready_i & ~bufferFull_o & ~flush_i & ~reset.
  - nWr = popcount of the 4 valid bits.
  - Valid packets are compacted in slot order 0→3 into entries tail, tail+1, ... (mod DEPTH).
  - Any valid pattern is legal. For example, pattern 1010 writes slot0 at tail and slot2 at tail+1.
  - When wr is 1, tail advances by nWr. When wr is 0, nothing is written.
- Read:
  - instBufferReady_o = (count >= 4) & ~flush_i & ~reset, combinational from registered count.
  - instNPacket_o = array[head+N mod DEPTH], combinational and valid only while instBufferReady_o=1.
  - rd = instBufferReady_o & ~stall_i. When rd is 1, head advances by 4.
  - stall_i does not drop instBufferReady_o; the same 4 packets are held until consumed.
- Occupancy: count_next = count + (wr ? nWr : 0) - (rd ? 4 : 0). Simultaneous read and write in one cycle are both honoured.
- Latency: a packet written in cycle N is readable at the earliest in cycle N+1.
- Wrap-around: a write or read window that crosses entry DEPTH-1 continues at entry 0 with no bubble.
- Flush (flush_i=1):
  - On the next edge: head=0, tail=0, count=0.
  - The same-cycle bundle is dropped and no read is performed.
  - flush_i has priority over write and read; reset has priority over flush_i.
- Boundary conditions:
  - count=DEPTH-4 → full=0; up to 4 packets written → count=DEPTH.
  - count=DEPTH-3 → full=1.
  - count=3 → ready=0; Decode receives nothing until a fourth packet arrives.
  - fs2Ready_i=0 or all valid bits 0 → no write, tail unchanged.
  - Reset asserted mid-stream → all state cleared on that edge, and outputs are 0 in the following cycle.

Test Plan:
- Reset, then 4 bundles with valid=1111, packets tagged 0x01..0x10, stall_i=0:
  - instBufferReady_o=1 from cycle 2 onward.
  - Outputs follow tag order 01-04, 05-08, ...
  - count_o settles at 4 (one bundle in flight).
- Bundles with valid patterns 1000, 1100, 1010, 0001 (tags A; B,C; D,E; F):
  - Compacted order A,B,C,D,E,F.
  - First group A-D is released the cycle after count reaches 4.
  - count_o=2 after the release.
- stall_i=1 with full bundles every cycle:
  - count_o rises 4, 8, 12.
  - bufferFull_o=1 at count 16 and again at 13.
  - Bundles presented while full are not written.
  - Releasing stall drains 4 per cycle.
- Wrap-around: preload so head=tail=14, then write 4 (tags W0-W3):
  - Entries 14, 15, 0, 1 receive W0-W3.
  - Read returns W0-W3 in order; head=2 afterwards.
- flush_i=1 with count=10 and a simultaneous valid=1111 write:
  - Next cycle count_o=0, instBufferReady_o=0, head=tail=0.
  - The flushed bundle never appears on the outputs.
- reset asserted while count=7 and a read is in progress:
  - Next cycle all outputs are 0 and count_o=0.
  - The first post-reset bundle appears at inst0Packet_o.
